tick_serializer: RTL and testbench

TICK_SERIALIZER -- requirements
Module: tick_serializer

---
 rtl/tick_serializer.sv | 104 ++++++++++
 tb/tb_tick_serializer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/tick_serializer.sv
// tick_serializer: shifts a W-bit codeword out one bit per slow_clk_i rising edge, seen as a one-cycle tick.
// Define TICK_SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module tick_serializer #(
  parameter int   W          = 15,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         slow_clk_i,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic         serial_o,
  output logic         busy_o,
  output logic         done_o
);
  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] LAST = CW'(W);
  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SHIFT,
`ifdef TICK_SERIALIZER_PARITY_EN
    PARITY,
`endif
    DONE
  } state_t;
  state_t state, nxt;
  logic s1, s2, hist, seen_low, tick;
  logic [1:0] warm;
  logic [W-1:0] sh;
  logic [CW-1:0] cnt;
  logic ser;
`ifdef TICK_SERIALIZER_PARITY_EN
  logic par;
`endif
  // seen_low blocks a false edge when slow_clk_i is already high as reset releases
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      hist     <= 1'b0;
      warm     <= 2'b00;
      seen_low <= 1'b0;
    end else begin
      s1       <= slow_clk_i;
      s2       <= s1;
      hist     <= s2;
      warm     <= {warm[0], 1'b1};
      seen_low <= seen_low | (warm[1] & ~s2);
    end
  end
  assign tick = s2 & ~hist & seen_low;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= nxt;
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   nxt = valid_i ? ARMED : IDLE;
      ARMED:  nxt = tick ? SHIFT : ARMED;
`ifdef TICK_SERIALIZER_PARITY_EN
      SHIFT:  nxt = (tick && cnt >= LAST) ? PARITY : SHIFT;
      PARITY: nxt = tick ? DONE : PARITY;
`else
      SHIFT:  nxt = (tick && cnt >= LAST) ? DONE : SHIFT;
`endif
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh  <= '0;
      cnt <= '0;
      ser <= IDLE_LEVEL;
`ifdef TICK_SERIALIZER_PARITY_EN
      par <= 1'b0;
`endif
    end else if (state == IDLE && valid_i) begin
      sh  <= data_i;
      cnt <= '0;
`ifdef TICK_SERIALIZER_PARITY_EN
      par <= ^data_i;
`endif
    end else if (tick && (state == ARMED || state == SHIFT) && cnt < LAST) begin
      ser <= (MSB_FIRST != 0) ? sh[W-1] : sh[0];
      sh  <= (MSB_FIRST != 0) ? sh << 1 : sh >> 1;
      cnt <= cnt + 1'b1;
    end else if (tick && state == SHIFT) begin
`ifdef TICK_SERIALIZER_PARITY_EN
      ser <= par;
    end else if (tick && state == PARITY) begin
`endif
      ser <= IDLE_LEVEL;
    end
  end
  assign ready_o  = state == IDLE;
  assign busy_o   = state != IDLE;
  assign done_o   = state == DONE;
  assign serial_o = ser;
endmodule

// File: tb/tb_tick_serializer.sv
// tb_tick_serializer: directed checks of tick_serializer (W=15, MSB first, slow clock = 8 clk_i cycles).
module tb_tick_serializer;
`ifdef TICK_SERIALIZER_PARITY_EN
  localparam int NB = 16;
`else
  localparam int NB = 15;
`endif
  logic clk = 1'b0, rst = 1'b1, slow = 1'b0, valid = 1'b0;
  logic [14:0] data = '0;
  logic ready, serial, busy, done;
  int ph = 7, nerr = 0, nchk = 0, ndone = 0;
  bit en = 1'b1;

  tick_serializer dut (
    .clk_i(clk), .rst_i(rst), .slow_clk_i(slow), .data_i(data), .valid_i(valid),
    .ready_o(ready), .serial_o(serial), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  // slow clock rises on the negedge where ph becomes 0; the FSM then acts on
  // the third following posedge, so the new bit is visible at the ph==3 sample
  always @(negedge clk) if (en) begin
    ph = (ph + 1) % 8;
    slow = ph < 4;
  end
  always @(negedge clk) if (done === 1'b1) ndone++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ph(input int p);
    do begin
      @(negedge clk);
      #1;
    end while (ph != p);
  endtask

  task automatic run_frame(input logic [14:0] w, input bit co, input bit junk,
                           input bit stall, input int abort);
    logic [15:0] e;
    int d0;
    for (int i = 0; i < 15; i++) e[i] = w[14-i];
    e[15] = ^w;
    wait_ph(co ? 2 : 5);
    chk("ready_before_send", ready, 1);
    d0 = ndone;
    data = w;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    if (stall) begin
      en = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      chk("stall_busy", busy, 1);
      chk("stall_serial", serial, 1);
      chk("stall_no_done", ndone, d0);
      en = 1'b1;
    end else begin
      @(negedge clk);
      #1;
      if (co) begin
        chk("coincident_tick_serial", serial, 1);
        chk("coincident_tick_busy", busy, 1);
      end
    end
    for (int i = 0; i < NB; i++) begin
      wait_ph(3);
      chk($sformatf("bit%0d_start", i), serial, e[i]);
      if (junk && i == 2) begin
        valid = 1'b1;
        data = ~w;
      end
      if (junk && i == NB - 1) valid = 1'b0;
      if (i == abort) begin
        rst = 1'b1;
        #1;
        chk("abort_serial", serial, 1);
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        chk("abort_release_serial", serial, 1);
        chk("abort_release_ready", ready, 1);
        return;
      end
      wait_ph(2);
      chk($sformatf("bit%0d_hold", i), serial, e[i]);
    end
    wait_ph(3);
    chk("done_pulse", done, 1);
    chk("done_serial_idle", serial, 1);
    chk("done_ready_low", ready, 0);
    @(negedge clk);
    #1;
    chk("after_done_low", done, 0);
    chk("after_done_ready", ready, 1);
    chk("after_done_busy", busy, 0);
    chk("done_count", ndone, d0 + 1);
  endtask

  initial begin
    int d;
    repeat (20) @(negedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_serial", serial, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("post_rst_ready", ready, 1);
    chk("post_rst_serial", serial, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_no_done", ndone, 0);
    run_frame(15'h4D2B, 1'b0, 1'b0, 1'b0, -1);
    run_frame(15'h1234, 1'b1, 1'b0, 1'b0, -1);
    run_frame(15'h4D2B, 1'b0, 1'b1, 1'b0, -1);
    d = ndone;
    run_frame(15'h4D2B, 1'b0, 1'b0, 1'b0, 5);
    repeat (12) @(negedge clk);
    #1;
    chk("abort_no_done_pulse", ndone, d);
    chk("abort_idle_busy", busy, 0);
    run_frame(15'h2A5C, 1'b0, 1'b0, 1'b1, -1);
    run_frame(15'h0007, 1'b0, 1'b0, 1'b0, -1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
